// File: rtl/mem_access_ctl.sv
// mem_access_ctl -- initiator-side load/store sequencer for the 64-bit memory tile.
//
// Takes one request at a time on a valid/ready handshake, drives the tile's
// level-sensitive opRd/opWr strobes for a single cycle per beat, waits a fixed
// RD_LATENCY after the strobe drops, captures the read value and returns a
// one-cycle response. OWORD (128-bit) accesses are split into two QWORD beats at
// addr and addr+8; the WAIT cycles between beats keep the strobe low.
//
// Optional feature (macro MEMACC_ALIGN_CHK_EN): natural-alignment check on
// accept; a misaligned request is answered with rspErr=1 and issues no strobe.
// Without the macro, rspErr is tied low and misaligned accesses go to the tile.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   reqValid/reqReady          request handshake (ready only in IDLE)
//   reqWr, reqMode, reqAddr    request kind, access mode, byte address
//   reqData                    store data (OWORD uses all 128 bits)
//   rspValid, rspData, rspErr  one-cycle completion, load result, error flag
//   memOpRd, memOpWr           read / write strobes to the tile
//   memOpMode, memAddr         mode and address to the tile
//   memWrValue, memRdValue     write / read data to / from the tile
module mem_access_ctl #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 48
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWr,
    input  logic [2:0]        reqMode,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [127:0]      reqData,
    output logic              rspValid,
    output logic [127:0]      rspData,
    output logic              rspErr,
    output logic              memOpRd,
    output logic              memOpWr,
    output logic [2:0]        memOpMode,
    output logic [ADDR_W-1:0] memAddr,
    output logic [63:0]       memWrValue,
    input  logic [63:0]       memRdValue
);

    localparam logic [2:0] M_NONE  = 3'd0;
    localparam logic [2:0] M_BYTE  = 3'd1;
    localparam logic [2:0] M_WORD  = 3'd2;
    localparam logic [2:0] M_DWORD = 3'd3;
    localparam logic [2:0] M_QWORD = 3'd4;
    localparam logic [2:0] M_OWORD = 3'd5;
    localparam logic [2:0] M_UBYTE = 3'd6;
    localparam logic [2:0] M_UWORD = 3'd7;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [2:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [127:0]        data_q, data_d;
    logic                beat_q, beat_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          cnt_dec;
    logic [127:0]        rsp_q, rsp_d;
`ifdef MEMACC_ALIGN_CHK_EN
    logic                err_q, err_d;

    function automatic logic misaligned(input logic [2:0] m, input logic [3:0] a);
        case (m)
            M_WORD, M_UWORD: return a[0] != 1'b0;
            M_DWORD:         return a[1:0] != 2'b00;
            M_QWORD:         return a[2:0] != 3'b000;
            M_OWORD:         return a[3:0] != 4'b0000;
            default:         return 1'b0;
        endcase
    endfunction
`endif

    assign cnt_dec = cnt_q - 4'd1;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
`ifdef MEMACC_ALIGN_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    wr_d   = reqWr;
                    mode_d = reqMode;
                    addr_d = reqAddr;
                    data_d = reqData;
                    beat_d = 1'b0;
                    // Result builds up in place; halves not written stay zero.
                    rsp_d  = '0;
`ifdef MEMACC_ALIGN_CHK_EN
                    err_d  = 1'b0;
`endif
                    if (reqMode == M_NONE) begin
                        state_d = RESP;
`ifdef MEMACC_ALIGN_CHK_EN
                    end else if (misaligned(reqMode, reqAddr[3:0])) begin
                        err_d   = 1'b1;
                        state_d = RESP;
`endif
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = 4'(RD_LATENCY);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_dec;
                // Counter hitting zero marks the edge where memRdValue is valid.
                if (cnt_dec == 4'd0) begin
                    if (!wr_q) begin
                        if (beat_q) rsp_d[127:64] = memRdValue;
                        else        rsp_d[63:0]   = memRdValue;
                    end
                    if (mode_q == M_OWORD && !beat_q) begin
                        beat_d  = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            mode_q  <= M_NONE;
            addr_q  <= '0;
            data_q  <= '0;
            beat_q  <= 1'b0;
            cnt_q   <= '0;
            rsp_q   <= '0;
`ifdef MEMACC_ALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
`ifdef MEMACC_ALIGN_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Strobes decode straight from the state register so reset drops them
    // without waiting for a clock edge.
    assign reqReady = (state_q == IDLE);
    assign rspValid = (state_q == RESP);
    assign rspData  = rsp_q;
    assign memOpRd  = (state_q == ISSUE) && !wr_q;
    assign memOpWr  = (state_q == ISSUE) && wr_q;

`ifdef MEMACC_ALIGN_CHK_EN
    assign rspErr = (state_q == RESP) && err_q;
`else
    assign rspErr = 1'b0;
`endif

    // Bus fields derive only from latched request state and the beat bit, so
    // they stay put from ISSUE through WAIT; address wraps at 2^ADDR_W.
    assign memAddr    = addr_q + (ADDR_W'(beat_q) << 3);
    assign memWrValue = beat_q ? data_q[127:64] : data_q[63:0];

    always_comb begin
        memOpMode = mode_q;
        if (mode_q == M_OWORD)                memOpMode = M_QWORD;
        else if (wr_q && mode_q == M_UBYTE)   memOpMode = M_BYTE;
        else if (wr_q && mode_q == M_UWORD)   memOpMode = M_WORD;
    end

endmodule

// File: tb/tb_mem_access_ctl.sv
// Bench for mem_access_ctl: a byte-addressed tile responder, a transaction-level
// model that predicts every bus cycle and response, a per-cycle compare process,
// and directed requests with literal expectations.
module tb_mem_access_ctl;

    localparam int L  = 1;
    localparam int AW = 48;
    localparam longint MASK = (longint'(1) << AW) - 1;

    logic            clk;
    logic            reset_n;
    logic            reqValid, reqReady, reqWr;
    logic [2:0]      reqMode;
    logic [AW-1:0]   reqAddr;
    logic [127:0]    reqData;
    logic            rspValid, rspErr;
    logic [127:0]    rspData;
    logic            memOpRd, memOpWr;
    logic [2:0]      memOpMode;
    logic [AW-1:0]   memAddr;
    logic [63:0]     memWrValue;
    logic [63:0]     memRdValue = '0;

    mem_access_ctl #(.RD_LATENCY(L), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqWr(reqWr),
        .reqMode(reqMode), .reqAddr(reqAddr), .reqData(reqData),
        .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
        .memOpRd(memOpRd), .memOpWr(memOpWr), .memOpMode(memOpMode),
        .memAddr(memAddr), .memWrValue(memWrValue), .memRdValue(memRdValue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit started = 0;
    int last_due = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- memories: tile contents and model contents ----------------
    logic [7:0] tmem[longint];
    logic [7:0] gmem[longint];

    function automatic logic [7:0] mb(bit t, longint a);
        longint k;
        k = a & MASK;
        if (t) return tmem.exists(k) ? tmem[k] : 8'h00;
        return gmem.exists(k) ? gmem[k] : 8'h00;
    endfunction

    function automatic logic [63:0] ld(bit t, longint a, int n, bit sx);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(mb(t, a + i)) << (8 * i));
        if (sx && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    function automatic logic [63:0] ld_mode(bit t, longint a, logic [2:0] m);
        case (m)
            3'd1:       return ld(t, a, 1, 1'b1);
            3'd2:       return ld(t, a, 2, 1'b1);
            3'd3:       return ld(t, a, 4, 1'b1);
            3'd4, 3'd5: return ld(t, a, 8, 1'b0);
            3'd6:       return ld(t, a, 1, 1'b0);
            3'd7:       return ld(t, a, 2, 1'b0);
            default:    return 64'd0;
        endcase
    endfunction

    function automatic int msize(logic [2:0] m);
        case (m)
            3'd1, 3'd6: return 1;
            3'd2, 3'd7: return 2;
            3'd3:       return 4;
            3'd4:       return 8;
            3'd5:       return 16;
            default:    return 0;
        endcase
    endfunction

    task automatic st(bit t, longint a, int n, logic [127:0] d);
        for (int i = 0; i < n; i++) begin
            longint k;
            k = (a + i) & MASK;
            if (t) tmem[k] = d[8*i +: 8];
            else   gmem[k] = d[8*i +: 8];
        end
    endtask

    // ---------------- tile responder ----------------
    // Read data becomes valid L edges after the strobe drops; junk before that.
    int          rcnt = 0;
    logic [63:0] rpend;
    always @(posedge clk) begin
        if (memOpWr)
            st(1'b1, longint'(memAddr), (msize(memOpMode) > 8) ? 8 : msize(memOpMode),
               {64'd0, memWrValue});
        if (memOpRd) begin
            rpend = ld_mode(1'b1, longint'(memAddr), memOpMode);
            rcnt  = L - 1;
            memRdValue <= (rcnt == 0) ? rpend : 64'hDEAD_BEEF_0BAD_F00D;
        end else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) memRdValue <= rpend;
        end
    end

    // ---------------- transaction model ----------------
    bit           e_rv[int];
    logic [127:0] e_data[int];
    bit           e_err[int];
    bit           e_rd[int];
    bit           e_wr[int];
    logic [AW-1:0] e_addr[int];
    logic [2:0]   e_mode[int];
    logic [63:0]  e_wv[int];
    bit           e_busy[int];

    function automatic logic [2:0] bus_mode(bit wr, logic [2:0] m);
        if (m == 3'd5) return 3'd4;
        if (wr && m == 3'd6) return 3'd1;
        if (wr && m == 3'd7) return 3'd2;
        return m;
    endfunction

    // A = first cycle after the accept edge. Each beat is one strobe cycle
    // followed by L quiet cycles; the response follows the last beat.
    task automatic push(int A, bit wr, logic [2:0] m, logic [AW-1:0] a,
                        logic [127:0] d, output int due);
        bit err;
        int nb;
        logic [127:0] r;
        err = 1'b0;
`ifdef MEMACC_ALIGN_CHK_EN
        begin
            int al;
            al = (m == 3'd5) ? 16 : (m == 3'd4) ? 8 : (m == 3'd3) ? 4 :
                 (m == 3'd2 || m == 3'd7) ? 2 : 1;
            err = (longint'(a) % al) != 0;
        end
`endif
        if (m == 3'd0 || err) begin
            due = A;
            r   = '0;
        end else begin
            nb = (m == 3'd5) ? 2 : 1;
            for (int b = 0; b < nb; b++) begin
                int s;
                s = A + b * (L + 1);
                if (wr) e_wr[s] = 1'b1;
                else    e_rd[s] = 1'b1;
                for (int c = s; c <= s + L; c++) begin
                    e_addr[c] = AW'((longint'(a) + 8 * b) & MASK);
                    e_mode[c] = bus_mode(wr, m);
                    if (wr) e_wv[c] = d[64*b +: 64];
                end
            end
            due = A + nb * (L + 1);
            if (wr) begin
                st(1'b0, longint'(a), msize(m), d);
                r = '0;
            end else if (m == 3'd5) begin
                r = {ld_mode(1'b0, longint'(a) + 8, 3'd4), ld_mode(1'b0, longint'(a), 3'd4)};
            end else begin
                r = {64'd0, ld_mode(1'b0, longint'(a), m)};
            end
        end
        e_rv[due]   = 1'b1;
        e_data[due] = r;
        e_err[due]  = err;
        for (int c = A; c <= due; c++) e_busy[c] = 1'b1;
        if (due > last_due) last_due = due;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started && reset_n) begin
            chk("rspValid", rspValid, e_rv.exists(cyc));
            if (e_rv.exists(cyc)) begin
                chk("rspData", rspData, e_data[cyc]);
                chk("rspErr", rspErr, e_err[cyc]);
            end
            chk("memOpRd", memOpRd, e_rd.exists(cyc));
            chk("memOpWr", memOpWr, e_wr.exists(cyc));
            if (e_addr.exists(cyc)) begin
                chk("memAddr", memAddr, e_addr[cyc]);
                chk("memOpMode", memOpMode, e_mode[cyc]);
            end
            if (e_wv.exists(cyc)) chk("memWrValue", memWrValue, e_wv[cyc]);
            chk("reqReady", reqReady, !e_busy.exists(cyc));
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge of the first cycle after accept.
    task automatic send(bit wr, logic [2:0] m, logic [AW-1:0] a, logic [127:0] d,
                        output int A, output int due);
        int k;
        reqWr = wr; reqMode = m; reqAddr = a; reqData = d; reqValid = 1'b1;
        k = 0;
        while (!reqReady && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!reqReady) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: reqReady stayed 0 for %0d cycles", k);
            reqValid = 1'b0;
            A = cyc;
            due = cyc;
            return;
        end
        A = cyc + 1;
        push(A, wr, m, a, d, due);
        @(negedge clk);
        reqValid = 1'b0;
    endtask

    task automatic to_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic expect_rsp(int c, logic [127:0] v, string nm);
        to_cyc(c);
        chk({nm, "_valid"}, rspValid, 1);
        chk({nm, "_data"}, rspData, v);
    endtask

    initial begin
        int A, due;
        reset_n = 1'b1;
        reqValid = 1'b0; reqWr = 1'b0; reqMode = '0; reqAddr = '0; reqData = '0;
        st(1'b1, 'h10, 4, 128'hFFFF_FFF0);
        st(1'b0, 'h10, 4, 128'hFFFF_FFF0);
        #1 reset_n = 1'b0;
        #2;
        chk("rst_reqReady", reqReady, 1);
        chk("rst_rspValid", rspValid, 0);
        chk("rst_rspErr", rspErr, 0);
        chk("rst_rspData", rspData, 0);
        chk("rst_memOpRd", memOpRd, 0);
        chk("rst_memOpWr", memOpWr, 0);
        chk("rst_memOpMode", memOpMode, 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_memWrValue", memWrValue, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        started = 1'b1;
        @(negedge clk);

        // DWORD load, sign-extended by the tile
        send(1'b0, 3'd3, 'h10, '0, A, due);
        chk("dw_strobe", memOpRd, 1);
        chk("dw_addr", memAddr, 'h10);
        chk("dw_mode", memOpMode, 3);
        expect_rsp(A + 2, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFF0, "dw");

        // OWORD store: two QWORD beats with a quiet cycle between
        send(1'b1, 3'd5, 'h20, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, A, due);
        chk("ow_wr0", memOpWr, 1);
        chk("ow_addr0", memAddr, 'h20);
        chk("ow_mode0", memOpMode, 4);
        chk("ow_wv0", memWrValue, 64'h2222_2222_2222_2222);
        to_cyc(A + 1);
        chk("ow_gap", memOpWr, 0);
        to_cyc(A + 2);
        chk("ow_wr1", memOpWr, 1);
        chk("ow_addr1", memAddr, 'h28);
        chk("ow_mode1", memOpMode, 4);
        chk("ow_wv1", memWrValue, 64'h1111_1111_1111_1111);
        expect_rsp(A + 4, '0, "ow_st");

        // OWORD load back
        send(1'b0, 3'd5, 'h20, '0, A, due);
        expect_rsp(A + 4, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, "ow_ld");

        // UBYTE store, then UBYTE load held valid through the busy period
        send(1'b1, 3'd6, 'h5, 128'hAB, A, due);
        chk("ub_wr", memOpWr, 1);
        chk("ub_mode", memOpMode, 1);
        chk("ub_wv", memWrValue, 64'hAB);
        send(1'b0, 3'd6, 'h5, '0, A, due);
        expect_rsp(A + 2, 128'hAB, "ub_ld");

        // NONE: response in the cycle straight after accept, no strobe
        send(1'b0, 3'd0, 'h40, '1, A, due);
        chk("none_valid", rspValid, 1);
        chk("none_data", rspData, 0);
        chk("none_rd", memOpRd, 0);
        chk("none_wr", memOpWr, 0);

        // Reset during the first-beat wait of an OWORD load
        send(1'b0, 3'd5, 'h20, '0, A, due);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_rd", memOpRd, 0);
        chk("mid_rst_wr", memOpWr, 0);
        chk("mid_rst_rv", rspValid, 0);
        chk("mid_rst_ready", reqReady, 1);
        e_rv.delete(); e_data.delete(); e_err.delete(); e_rd.delete(); e_wr.delete();
        e_addr.delete(); e_mode.delete(); e_wv.delete(); e_busy.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", reqReady, 1);
        send(1'b0, 3'd4, 'h20, '0, A, due);
        expect_rsp(A + 2, 128'h2222_2222_2222_2222, "qw_after_rst");

        // Misaligned QWORD load at 0x3
        send(1'b0, 3'd4, 'h3, '0, A, due);
`ifdef MEMACC_ALIGN_CHK_EN
        chk("mis_valid", rspValid, 1);
        chk("mis_err", rspErr, 1);
        chk("mis_rd", memOpRd, 0);
`else
        chk("mis_rd", memOpRd, 1);
        chk("mis_addr", memAddr, 'h3);
        expect_rsp(A + 2, 128'h00AB_0000, "mis");
        chk("mis_err", rspErr, 0);
`endif

        // OWORD store whose second beat wraps the address space, then read 0
        send(1'b1, 3'd5, 48'hFFFF_FFFF_FFF8,
             {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444}, A, due);
        send(1'b0, 3'd4, 'h0, '0, A, due);

        to_cyc(last_due + 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctl.md
Name: mem_access_ctl

Overview:
- Initiator-side load/store sequencer for the 64-bit memory tile.
- Accepts one CPU-side request at a time on a valid/ready handshake.
- Drives the tile's level-sensitive opRd/opWr strobes, opMode, address and write data; captures the read value after a fixed latency and returns a single-cycle response.
- Splits 128-bit OWORD accesses into two QWORD beats. Guarantees the strobe-low gap the tile needs between accesses.

Parameters:
- RD_LATENCY, 1: cycles from strobe deassert to valid memRdValue; legal range 1..15.
- ADDR_W, 48: address width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous active-low reset.
- reqValid  in  1  request valid.
- reqReady  out  1  controller idle and able to accept a request.
- reqWr  in  1  1 = store, 0 = load.
- reqMode  in  3  access mode: NONE=0, BYTE=1, WORD=2, DWORD=3, QWORD=4, OWORD=5, UBYTE=6, UWORD=7.
- reqAddr  in  ADDR_W  byte address.
- reqData  in  128  store data; OWORD uses all bits, other modes use [63:0].
- rspValid  out  1  one-cycle completion pulse.
- rspData  out  128  load result.
- rspErr  out  1  error flag, qualified by rspValid.
- memOpRd  out  1  read strobe to the tile.
- memOpWr  out  1  write strobe to the tile.
- memOpMode  out  3  mode to the tile.
- memAddr  out  ADDR_W  address to the tile.
- memWrValue  out  64  write data to the tile.
- memRdValue  in  64  read data from the tile.

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - memOpRd, memOpWr, rspValid and rspErr go to 0.
  - memOpMode, memAddr, memWrValue and rspData go to 0.
  - Beat and latency counter clear to 0.
  - reqReady=1 once IDLE.
- Reset mid-transaction drops strobes immediately, abandons the transaction, and produces no rspValid.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqReady=1.
  - On reqValid=1, latch reqWr, reqMode, reqAddr and reqData.
  - reqMode=NONE goes straight to RESP with rspData=0.
  - Any other mode sets beat=0 and goes to ISSUE.
- ISSUE (exactly 1 cycle):
  - Assert memOpRd (load) or memOpWr (store); never both.
  - memAddr = latched address + 8*beat, modulo 2^ADDR_W; wraps silently.
  - memOpMode:
    - OWORD is sent as QWORD.
    - On stores, UBYTE/UWORD are sent as BYTE/WORD.
    - On loads, the mode passes through unchanged.
  - memWrValue = reqData[63:0] for beat 0, reqData[127:64] for beat 1.
  - Load counter with RD_LATENCY; next state WAIT.
- WAIT:
  - Strobes low and the counter decrements each cycle.
  - When the counter reaches 0:
    - Loads capture memRdValue into rspData[63:0] (beat 0) or rspData[127:64] (beat 1).
  - Then:
    - If OWORD and beat=0: set beat=1 and go to ISSUE. The WAIT cycles provide the mandatory strobe-low gap.
    - Otherwise go to RESP.
- Memory outputs:
  - memAddr, memOpMode and memWrValue hold stable from ISSUE through the end of WAIT.
- RESP:
  - rspValid=1 for exactly one cycle, then IDLE. No backpressure.
  - Non-OWORD loads: rspData[127:64]=0.
  - Stores: rspData=0.
- Handshake and throughput:
  - reqReady=0 in all states except IDLE. A request held valid through a busy period is accepted at the next IDLE.
  - Back-to-back requests: minimum spacing between strobes is RD_LATENCY+2 cycles, because the RESP and IDLE cycles keep strobes low.
- Latency, accept edge to rspValid:
  - Non-OWORD: RD_LATENCY+2 cycles.
  - OWORD: 2*RD_LATENCY+3 cycles.
  - NONE: 1 cycle.
- rspErr=0 unless the optional feature is enabled.

Optional Feature:
- Macro: MEMACC_ALIGN_CHK_EN.
- Enabled:
  - In IDLE, an accepted request is checked for natural alignment:
    - WORD/UWORD: addr[0]=0.
    - DWORD: addr[1:0]=0.
    - QWORD: addr[2:0]=0.
    - OWORD: addr[3:0]=0.
    - BYTE/UBYTE/NONE: always aligned.
  - A misaligned request goes directly to RESP with rspErr=1 and rspData=0. No strobe is issued.
- Disabled:
  - No check is made; misaligned accesses are issued as-is (the tile handles byte shifts).
  - rspErr is tied to 0.

Test Plan:
- Reset, then load DWORD at 0x10 with the tile holding 0xFFFF_FFF0 at 0x10 and RD_LATENCY=1:
  - memOpRd high exactly 1 cycle with memAddr=0x10 and memOpMode=3.
  - rspValid 3 cycles after accept; rspData=0xFFFF_FFFF_FFFF_FFF0.
- Store OWORD 0x1111..._2222... at 0x20:
  - Two memOpWr pulses, memAddr 0x20 then 0x28, memOpMode=4 both times, separated by ≥1 low cycle.
  - memWrValue 0x2222_2222_2222_2222 then 0x1111_1111_1111_1111.
  - Follow-up OWORD load returns the identical 128-bit value.
- Store UBYTE 0xAB at 0x5:
  - memOpMode=1 on the bus.
  - A subsequent UBYTE load at 0x5 gives rspData=0x00..00AB.
- reqMode=NONE: rspValid the next cycle, rspData=0, no strobe asserted.
- Assert reset_n=0 during the WAIT of an OWORD load's first beat:
  - Strobes 0 immediately, no rspValid, reqReady=1 after release.
  - A new QWORD load completes normally.
- With MEMACC_ALIGN_CHK_EN: QWORD load at 0x3 gives rspErr=1 and no memOpRd. Without the macro: the strobe is issued with memAddr=0x3 and rspErr=0.
